cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Request-sequencing FSM directly upstream of the 4-way set-associative cache array (32 sets, 1 word/line, index = address[6:2]).
- Accepts single-word CPU loads/stores and drives the array's read/write/replace_way inputs.
- On read miss, fetches from main memory over a req/ack handshake and fills the array.
- Stores are write-through, write-allocate. Owns per-set round-robin replacement pointers and hit/miss statistics.

Parameters:
NUM_SETS, 32, sets in array; index width log2(NUM_SETS)=5, index = addr[6:2]
NUM_WAYS, 4, ways per set; replace_way width log2(NUM_WAYS)=2
CNT_W, 16, width of hit/miss statistic counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  request strobe, sampled in IDLE only
cpu_we  in  1  1=store, 0=load
cpu_addr  in  32  byte address (word aligned)
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid when cpu_done=1
cpu_done  out  1  one-cycle completion pulse
cpu_busy  out  1  high whenever state != IDLE
cache_read  out  1  array read enable
cache_write  out  1  array write enable
cache_addr  out  32  array address (latched request address)
cache_wdata  out  32  array write data
cache_rdata  in  32  array read data (combinational)
cache_hit  in  1  array hit (combinational, valid while cache_read=1)
replace_way  out  2  victim way for array allocation
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write qualifier
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
hit_count  out  CNT_W  saturating lookup-hit counter
miss_count  out  CNT_W  saturating lookup-miss counter

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0, including cpu_rdata, hit_count and miss_count.
  - All rr_ptr[set]=0; latched request registers cleared.
  - Reset mid-operation aborts immediately; mem_req drops the same instant; no cpu_done.
- The array's own reset is active-high; the integrating top inverts reset for it.
- States: IDLE, LOOKUP, WR_CACHE, MEM_RD, FILL, MEM_WR, RESP.
- IDLE: if cpu_req=1, latch addr/we/wdata and go to LOOKUP. cpu_req while busy is ignored (not queued).
- LOOKUP (1 cycle): cache_read=1, cache_addr=latched addr.
  - Register hit flag; increment hit_count or miss_count (saturate at all-ones, no wrap).
  - Load hit: cpu_rdata<=cache_rdata, go to RESP.
  - Load miss: go to MEM_RD.
  - Store: go to WR_CACHE.
- WR_CACHE (1 cycle): cache_write=1, cache_wdata=latched wdata, replace_way=rr_ptr[idx].
  - If the registered flag is a miss, rr_ptr[idx]<=rr_ptr[idx]+1 (mod 4); on a hit the pointer is unchanged.
  - Go to MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr, all stable until mem_ack.
  - mem_ack may arrive in the first cycle of mem_req.
  - On ack: capture mem_rdata into the fill register and cpu_rdata; go to FILL.
- FILL (1 cycle): cache_write=1, cache_wdata=fill data, replace_way=rr_ptr[idx]; rr_ptr[idx]++ mod 4; go to RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata; on mem_ack go to RESP.
- RESP (1 cycle): cpu_done=1, cpu_rdata held; go to IDLE.
  - cpu_rdata retains its value until the next load completes.
  - Stores leave cpu_rdata unchanged.
- cache_read and cache_write are never both 1. Both are 0 outside LOOKUP, WR_CACHE and FILL.
- mem_req is asserted only in MEM_RD and MEM_WR. mem_ack outside these states is ignored.
- Latency (req sampled at edge N):
  - Load hit: cpu_done at cycle N+2.
  - Load miss: cpu_done = ack cycle + 2.
  - Store: cpu_done = ack cycle + 1.
- rr_ptr wraps 3->0. Each set's pointer advances independently.

Test Plan:
- Reset, then load 0x0000_0040 with mem returning 0xDEAD_BEEF after 3 cycles -> one MEM_RD, FILL with replace_way=0, cpu_rdata=0xDEAD_BEEF, miss_count=1.
- Repeat the same load -> no mem_req, cpu_done at N+2, cpu_rdata=0xDEAD_BEEF, hit_count=1.
- Five misses to set 0 (tags 0x0,0x1,0x2,0x3,0x4 at addr[31:7]) -> replace_way sequence 0,1,2,3,0; set 1 pointer stays 0.
- Store 0x1234_5678 to 0x0000_0040 (hit) -> cache_write with pointer unchanged, then mem_req+mem_we with mem_wdata=0x1234_5678; a following load hits and returns 0x1234_5678.
- Assert reset low while in MEM_RD -> mem_req=0, cpu_busy=0, counters=0 immediately; late mem_ack ignored; no cpu_done.
- Drive cpu_req during a miss, and mem_ack in the same cycle mem_req rises -> extra request ignored; same-cycle ack accepted, FILL next cycle.

Source files
------------

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - request sequencer in front of a set-associative cache array
//
// Purpose:
//   Sequences single-word CPU loads and stores against a 4-way set-associative
//   cache array (1 word/line). Read misses fetch from memory and fill the array.
//   Stores are write-through, write-allocate. Owns the per-set round-robin
//   victim pointers and saturating hit/miss statistics.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request, sampled only when idle
//   cpu_rdata/done/busy        load data, one-cycle completion pulse, busy flag
//   cache_read/write/addr/     array control; cache_rdata/cache_hit are
//   cache_wdata/replace_way    combinational returns from the array
//   mem_req/we/addr/wdata      memory request, held until mem_ack
//   mem_rdata/mem_ack          memory return data and one-cycle completion
//   hit_count/miss_count       saturating lookup statistics
module cache_controller #(
  parameter int NUM_SETS = 32,
  parameter int NUM_WAYS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_done,
  output logic                        cpu_busy,
  output logic                        cache_read,
  output logic                        cache_write,
  output logic [31:0]                 cache_addr,
  output logic [31:0]                 cache_wdata,
  input  logic [31:0]                 cache_rdata,
  input  logic                        cache_hit,
  output logic [$clog2(NUM_WAYS)-1:0] replace_way,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata,
  input  logic                        mem_ack,
  output logic [CNT_W-1:0]            hit_count,
  output logic [CNT_W-1:0]            miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WR_CACHE, MEM_RD, FILL, MEM_WR, RESP
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              hit_q;
  logic [31:0]       fill_q;
  logic [31:0]       rdata_q;
  logic [WAY_W-1:0]  rr_ptr [NUM_SETS];
  logic [IDX_W-1:0]  idx;

  assign idx = addr_q[IDX_W+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      fill_q     <= '0;
      rdata_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int i = 0; i < NUM_SETS; i++) rr_ptr[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
          end
        end
        LOOKUP: begin
          hit_q <= cache_hit;
          if (cache_hit) begin
            if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
          end else begin
            if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
          end
          if (!we_q && cache_hit) rdata_q <= cache_rdata;
        end
        // A store hit overwrites the hitting way, so only an allocation
        // consumes the victim pointer.
        WR_CACHE: if (!hit_q) rr_ptr[idx] <= rr_ptr[idx] + 1'b1;
        MEM_RD: begin
          if (mem_ack) begin
            fill_q  <= mem_rdata;
            rdata_q <= mem_rdata;
          end
        end
        FILL: rr_ptr[idx] <= rr_ptr[idx] + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    cpu_done    = 1'b0;
    cpu_busy    = (state != IDLE);
    cache_read  = 1'b0;
    cache_write = 1'b0;
    cache_wdata = '0;
    replace_way = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE:     if (cpu_req) state_nxt = LOOKUP;
      LOOKUP: begin
        cache_read = 1'b1;
        if (we_q)           state_nxt = WR_CACHE;
        else if (cache_hit) state_nxt = RESP;
        else                state_nxt = MEM_RD;
      end
      WR_CACHE: begin
        cache_write = 1'b1;
        cache_wdata = wdata_q;
        replace_way = rr_ptr[idx];
        state_nxt   = MEM_WR;
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) state_nxt = FILL;
      end
      FILL: begin
        cache_write = 1'b1;
        cache_wdata = fill_q;
        replace_way = rr_ptr[idx];
        state_nxt   = RESP;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) state_nxt = RESP;
      end
      RESP: begin
        cpu_done  = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  assign cache_addr = addr_q;
  assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller
//
// Purpose:
//   Emulates the cache array and main memory around the controller and checks
//   each transaction against a reference model of the cache contents, the
//   per-set allocation order and the expected completion latency.
//
// Ports: none (top-level bench).
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_busy;
  logic        cache_read, cache_write;
  logic [31:0] cache_addr, cache_wdata, cache_rdata;
  logic        cache_hit;
  logic [1:0]  replace_way;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
    .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .replace_way(replace_way),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Cache array emulation: reset together with the controller, writes land in
  // the hitting way if the tag is present, otherwise in replace_way.
  logic        arr_v [32][4];
  logic [24:0] arr_t [32][4];
  logic [31:0] arr_d [32][4];

  always_comb begin
    cache_hit   = 1'b0;
    cache_rdata = '0;
    if (cache_read) begin
      for (int w = 0; w < 4; w++) begin
        if (arr_v[cache_addr[6:2]][w] && arr_t[cache_addr[6:2]][w] == cache_addr[31:7]) begin
          cache_hit   = 1'b1;
          cache_rdata = arr_d[cache_addr[6:2]][w];
        end
      end
    end
  end

  always @(posedge clk) begin : array_write
    int hw;
    if (!reset) begin
      for (int s = 0; s < 32; s++)
        for (int w = 0; w < 4; w++) arr_v[s][w] <= 1'b0;
    end else if (cache_write) begin
      hw = int'(replace_way);
      for (int w = 0; w < 4; w++)
        if (arr_v[cache_addr[6:2]][w] && arr_t[cache_addr[6:2]][w] == cache_addr[31:7]) hw = w;
      arr_v[cache_addr[6:2]][hw] <= 1'b1;
      arr_t[cache_addr[6:2]][hw] <= cache_addr[31:7];
      arr_d[cache_addr[6:2]][hw] <= cache_wdata;
    end
  end

  // Reference model: memory is authoritative (write-through), the cache holds
  // tags only, allocations go round-robin per set.
  logic [31:0] mem_model [logic [31:0]];
  bit          ref_v [32][4];
  logic [24:0] ref_t [32][4];
  int          ref_ptr [32];
  int          ref_hits, ref_misses;
  logic [31:0] ref_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int s = 0; s < 32; s++) begin
      ref_ptr[s] = 0;
      for (int w = 0; w < 4; w++) ref_v[s][w] = 1'b0;
    end
    ref_hits   = 0;
    ref_misses = 0;
    ref_rdata  = '0;
  endtask

  // One CPU transaction. lat = cycles of mem_req before mem_ack (0 = same
  // cycle). poke drives cpu_req while the controller is waiting on memory.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input bit poke);
    int set, exp_way, exp_done, done_k, req_cycles, writes, bad_rw;
    bit exp_hit;
    logic [31:0] exp_data, wr_data, rd_at_done, m_addr, m_wdata;
    logic [1:0]  wr_way;
    logic        m_we;
    set = int'(addr[6:2]);
    exp_hit = 1'b0;
    for (int w = 0; w < 4; w++)
      if (ref_v[set][w] && ref_t[set][w] == addr[31:7]) exp_hit = 1'b1;
    exp_way  = ref_ptr[set];
    exp_data = we ? wdata : mem_val(addr);
    exp_done = (!we && exp_hit) ? 1 : lat + 3;
    if (exp_hit) ref_hits++; else ref_misses++;

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    done_k = -1; req_cycles = 0; writes = 0; bad_rw = 0;
    wr_way = '0; wr_data = '0; rd_at_done = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
    for (int k = 0; k < 60 && done_k < 0; k++) begin
      mem_ack = 1'b0;
      cpu_req = 1'b0;
      if (cache_read && cache_write) bad_rw++;
      if (cache_write) begin writes++; wr_way = replace_way; wr_data = cache_wdata; end
      if (mem_req) begin
        if (req_cycles == lat) begin mem_ack = 1'b1; mem_rdata = mem_val(addr); end
        req_cycles++;
        m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
        if (poke) begin cpu_req = 1'b1; cpu_addr = addr ^ 32'h0000_0f80; end
      end
      if (cpu_done) begin done_k = k; rd_at_done = cpu_rdata; end
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;

    check("done_cycle", done_k, exp_done);
    check("rd_wr_overlap", bad_rw, 0);
    check("cache_writes", writes, (!we && exp_hit) ? 0 : 1);
    if (!(!we && exp_hit)) begin
      check("replace_way", {30'd0, wr_way}, exp_way);
      check("cache_wdata", wr_data, exp_data);
      check("mem_req_cycles", req_cycles, lat + 1);
      check("mem_we", {31'd0, m_we}, {31'd0, we});
      check("mem_addr", m_addr, addr);
      if (we) check("mem_wdata", m_wdata, wdata);
    end else begin
      check("mem_req_cycles", req_cycles, 0);
    end
    if (!we) ref_rdata = exp_data;
    check("cpu_rdata", rd_at_done, ref_rdata);
    check("hit_count", {16'd0, hit_count}, ref_hits);
    check("miss_count", {16'd0, miss_count}, ref_misses);
    check("idle_after", {30'd0, cpu_busy, cpu_done}, 0);

    if (!exp_hit) begin
      ref_v[set][ref_ptr[set]] = 1'b1;
      ref_t[set][ref_ptr[set]] = addr[31:7];
      ref_ptr[set] = (ref_ptr[set] + 1) % 4;
    end
    if (we) mem_model[addr] = wdata;
  endtask

  initial begin
    int seen;
    ref_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu", {cpu_rdata[30:0] | {30'd0, cpu_done}, cpu_busy}, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cache_ctl", {28'd0, cache_read, cache_write, replace_way}, 0);
    check("rst_cache_addr", cache_addr, 0);
    check("rst_cache_wdata", cache_wdata, 0);
    check("rst_mem_ctl", {30'd0, mem_req, mem_we}, 0);
    check("rst_mem_addr", mem_addr | mem_wdata, 0);
    check("rst_counts", {hit_count, miss_count}, 0);
    reset = 1'b1;

    // Miss then hit on the same line.
    mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
    do_op(1'b0, 32'h0000_0040, 32'h0, 3, 1'b0);
    do_op(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0);

    // Five misses to set 0 walk the pointer 0,1,2,3,0; set 1 is untouched.
    for (int t = 0; t < 5; t++) do_op(1'b0, 32'(t) << 7, 32'h0, t % 3, 1'b0);
    do_op(1'b0, 32'h0000_0004, 32'h0, 1, 1'b0);

    // Store hit, then a load hit returning the stored word.
    do_op(1'b1, 32'h0000_0040, 32'h1234_5678, 2, 1'b0);
    do_op(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0);

    // Same-cycle ack with a stray request during the miss.
    do_op(1'b0, 32'h0000_0288, 32'h0, 0, 1'b1);
    do_op(1'b1, 32'h0000_0308, 32'hCAFE_F00D, 0, 1'b1);

    // Randomized mix over a small tag/set space so hits and evictions occur.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] a;
      a = {22'd0, 3'($urandom_range(0, 5)), 5'($urandom_range(0, 2)), 2'b00};
      do_op(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting in MEM_RD aborts at once; a late ack is ignored.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0700;
    @(posedge clk); @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_mem_req", {31'd0, mem_req}, 1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_mem_req", {31'd0, mem_req}, 0);
    check("arst_busy", {31'd0, cpu_busy}, 0);
    check("arst_counts", {hit_count, miss_count}, 0);
    check("arst_cpu_rdata", cpu_rdata, 0);
    ref_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cpu_done || cpu_busy || mem_req) seen++;
    end
    check("late_ack_ignored", seen, 0);

    // Controller and pointers start fresh after reset.
    do_op(1'b0, 32'h0000_0040, 32'h0, 1, 1'b0);
    do_op(1'b0, 32'h0000_0080, 32'h0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
